ws_led_decoder: RTL

- Receives the single-wire serial LED waveform that our LED control unit produces and recovers the 24-bit colour words from it, which makes it the receive end of the LED protocol.
- Used in loopback self-test: it decodes a strip data line, or another FPGA's LED output, so the decoded colours can be compared against what the SPI receiver loaded.
- Runs on the PLL clock (fclk domain). Bit encoding: '0' = high for about 40 cycles, '1' = high for about 80 cycles, bit period about 126 cycles. A long low marks end of frame.

---
 rtl/led_pkg.sv | 8 +
 rtl/sync2.sv | 14 +
 rtl/ws_led_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// led_pkg: LED protocol timing shared with the LED control unit, plus decoder states.
package led_pkg;
  localparam int BITS_PER_LED = 24;
  localparam int T0H = 40;
  localparam int T1H = 80;
  localparam int T_BIT = 126;
  typedef enum logic [1:0] {IDLE, HIGH, STUCK, LOW} dec_state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for an asynchronous single-bit input.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ff <= '0;
    else r_ff <= {r_ff[0], i_d};
  end
  assign o_q = r_ff[1];
endmodule

// File: rtl/ws_led_decoder.sv
// ws_led_decoder: recovers 24-bit colour words from the single-wire LED waveform.
module ws_led_decoder
  import led_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_HIGH  = 10,
  parameter int THRESH    = 60,
  parameter int MAX_HIGH  = 110,
  parameter int RESET_LOW = 250
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    din,
  output logic [BITS_PER_LED-1:0] colorbits,
  output logic                    color_valid,
  output logic                    frame_done,
  output logic [7:0]              frame_words,
  output logic                    err
);
  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] L_THR  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] L_RST  = CNT_W'(RESET_LOW);
  localparam logic [4:0]       L_LAST = 5'(BITS_PER_LED - 1);

  dec_state_t              r_state, w_state_nx;
  logic                    w_din_s, r_din_q, w_rise, w_fall, w_bit;
  logic [1:0]              r_warm;
  logic                    r_armed;
  logic [CNT_W-1:0]        r_hcnt, r_lcnt, w_hcnt_nx, w_lcnt_nx, w_hinc, w_linc;
  logic [BITS_PER_LED-1:0] r_shreg, w_shreg_nx, r_colorbits, w_colorbits_nx;
  logic [4:0]              r_bitcnt, w_bitcnt_nx;
  logic [7:0]              r_wcnt, w_wcnt_nx, r_words, w_words_nx;
  logic                    r_valid, w_valid_nx, r_done, w_done_nx, r_err, w_err_nx;

  sync2 u_sync (.clk(clk), .reset_n(reset_n), .i_d(din), .o_q(w_din_s));

  assign w_rise = w_din_s & ~r_din_q;
  assign w_fall = ~w_din_s & r_din_q;
  assign w_hinc = (&r_hcnt) ? r_hcnt : r_hcnt + 1'b1;
  assign w_linc = (&r_lcnt) ? r_lcnt : r_lcnt + 1'b1;
  assign w_bit  = (r_hcnt >= L_THR);

  // A line already high at reset release must be seen low once before rises count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_din_q <= 1'b0;
      r_warm  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_din_q <= w_din_s;
      r_warm  <= (r_warm == 2'd2) ? r_warm : r_warm + 2'd1;
      r_armed <= r_armed | ((r_warm == 2'd2) & ~w_din_s);
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_hcnt_nx      = r_hcnt;
    w_lcnt_nx      = r_lcnt;
    w_shreg_nx     = r_shreg;
    w_bitcnt_nx    = r_bitcnt;
    w_wcnt_nx      = r_wcnt;
    w_colorbits_nx = r_colorbits;
    w_valid_nx     = 1'b0;
    w_done_nx      = 1'b0;
    w_words_nx     = '0;
    w_err_nx       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && r_armed) begin
          w_state_nx = HIGH;
          w_hcnt_nx  = CNT_W'(1);
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_state_nx = LOW;
          w_lcnt_nx  = CNT_W'(1);
          if (r_hcnt < L_MIN) begin
            w_err_nx = 1'b1;
          end else if (r_bitcnt == L_LAST) begin
            w_colorbits_nx = {r_shreg[BITS_PER_LED-2:0], w_bit};
            w_valid_nx     = 1'b1;
            w_bitcnt_nx    = '0;
            w_wcnt_nx      = (&r_wcnt) ? r_wcnt : r_wcnt + 8'd1;
          end else begin
            w_shreg_nx  = {r_shreg[BITS_PER_LED-2:0], w_bit};
            w_bitcnt_nx = r_bitcnt + 5'd1;
          end
        end else begin
          w_hcnt_nx = w_hinc;
          if (w_hinc >= L_MAX) begin
            w_err_nx    = 1'b1;
            w_bitcnt_nx = '0;
            w_state_nx  = STUCK;
          end
        end
      end
      STUCK: begin
        if (w_fall) begin
          w_state_nx = LOW;
          w_lcnt_nx  = CNT_W'(1);
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_nx = HIGH;
          w_hcnt_nx  = CNT_W'(1);
        end else begin
          w_lcnt_nx = w_linc;
          if (w_linc >= L_RST) begin
            w_done_nx   = 1'b1;
            w_words_nx  = r_wcnt;
            w_err_nx    = (r_bitcnt != '0);
            w_bitcnt_nx = '0;
            w_wcnt_nx   = '0;
            w_state_nx  = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_hcnt      <= '0;
      r_lcnt      <= '0;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_wcnt      <= '0;
      r_colorbits <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_words     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_hcnt      <= w_hcnt_nx;
      r_lcnt      <= w_lcnt_nx;
      r_shreg     <= w_shreg_nx;
      r_bitcnt    <= w_bitcnt_nx;
      r_wcnt      <= w_wcnt_nx;
      r_colorbits <= w_colorbits_nx;
      r_valid     <= w_valid_nx;
      r_done      <= w_done_nx;
      r_words     <= w_words_nx;
      r_err       <= w_err_nx;
    end
  end

  assign colorbits   = r_colorbits;
  assign color_valid = r_valid;
  assign frame_done  = r_done;
  assign frame_words = r_words;
  assign err         = r_err;
endmodule
